// File: rtl/disp_scan_decoder_pkg.sv
// rtl/disp_scan_decoder_pkg.sv - shared 7-segment display constants, glyph table and helpers
`timescale 1ns/1ps
package disp_scan_decoder_pkg;

   localparam int DIGITS = 8;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-high gfedcba patterns, index = nibble value; the display driver encodes with these
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_CAPT = 2'd1,
      ST_HOLD = 2'd2
   } scan_state_t;

   function automatic logic an_sel_ok(input logic [DIGITS-1:0] an_n);
      return $onehot(~an_n);
   endfunction

   function automatic logic [2:0] an_index(input logic [DIGITS-1:0] an_n);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!an_n[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/disp_glyph_decode.sv
// rtl/disp_glyph_decode.sv - combinational active-low 7-segment glyph to hex nibble decoder
`timescale 1ns/1ps
module disp_glyph_decode
   import disp_scan_decoder_pkg::*;
(
   input  logic [6:0] i_seg_n,
   output logic       o_valid,
   output logic [3:0] o_nibble
);

   logic [6:0] w_seg;

   assign w_seg = ~i_seg_n;

   always_comb begin
      o_valid  = 1'b0;
      o_nibble = 4'h0;
      for (int k = 0; k < 16; k++) begin
         if (w_seg == GLYPH[k]) begin
            o_valid  = 1'b1;
            o_nibble = 4'(k);
         end
      end
   end

endmodule

// File: rtl/disp_scan_decoder.sv
// rtl/disp_scan_decoder.sv - samples a multiplexed 8-digit display scan and rebuilds the 32-bit word
`timescale 1ns/1ps
module disp_scan_decoder
   import disp_scan_decoder_pkg::*;
#(
   parameter int SettleCnt  = 4,
   parameter int TimeoutCnt = 65536
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg_n,
   input  logic [7:0]  an_n,
   output logic [31:0] data,
   output logic        data_valid,
   output logic        glyph_err,
   output logic        stale,
   output logic [15:0] frame_cnt
);

   localparam int StabW = $clog2(SettleCnt + 1);
   localparam int TmoW  = $clog2(TimeoutCnt);
   localparam logic [StabW-1:0] STAB_MAX = StabW'(SettleCnt);
   localparam logic [StabW-1:0] STAB_ARM = StabW'(SettleCnt - 1);
   localparam logic [TmoW-1:0]  TMO_MAX  = TmoW'(TimeoutCnt - 1);
   localparam logic [TmoW-1:0]  TMO_ARM  = TmoW'(TimeoutCnt - 2);

   logic [6:0]        r_seg_m, r_seg_s;
   logic [7:0]        r_an_m, r_an_s;
   logic [14:0]       r_prev;
   logic [StabW-1:0]  r_stab;
   scan_state_t       r_state;
   logic [31:0]       r_shadow;
   logic [7:0]        r_seen;
   logic              r_bad;
   logic              r_done;
   logic [TmoW-1:0]   r_tmo;

   logic [14:0]       w_cur;
   logic              w_chg;
   logic              w_sel_ok;
   logic [2:0]        w_idx;
   logic              w_dec_valid;
   logic [3:0]        w_dec_nib;
   logic [7:0]        w_seen_next;
   logic              w_unused_dp;

   // The decimal point never reaches the synchronizer, so it cannot disturb settling
   assign w_unused_dp = seg_n[SEG_DP];

   assign w_cur       = {r_an_s, r_seg_s};
   assign w_chg       = (w_cur != r_prev);
   assign w_sel_ok    = an_sel_ok(r_an_s);
   assign w_idx       = an_index(r_prev[14:7]);
   assign w_seen_next = r_seen | (8'(1) << w_idx);

   // In CAPT, r_prev holds the glyph that was verified stable on the WAIT->CAPT edge
   disp_glyph_decode u_decode (
      .i_seg_n  (r_prev[6:0]),
      .o_valid  (w_dec_valid),
      .o_nibble (w_dec_nib)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg_m    <= '0;
         r_seg_s    <= '0;
         r_an_m     <= '0;
         r_an_s     <= '0;
         r_prev     <= '0;
         r_stab     <= '0;
         r_state    <= ST_WAIT;
         r_shadow   <= '0;
         r_seen     <= '0;
         r_bad      <= 1'b0;
         r_done     <= 1'b0;
         r_tmo      <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         glyph_err  <= 1'b0;
         stale      <= 1'b1;
         frame_cnt  <= '0;
      end else begin
         r_seg_m    <= seg_n[6:0];
         r_seg_s    <= r_seg_m;
         r_an_m     <= an_n;
         r_an_s     <= r_an_m;
         r_prev     <= w_cur;
         data_valid <= 1'b0;
         glyph_err  <= 1'b0;
         r_done     <= 1'b0;

         if (w_chg)
            r_stab <= '0;
         else if (r_stab != STAB_MAX)
            r_stab <= r_stab + 1'b1;

         case (r_state)
            ST_WAIT: begin
               if (!w_chg && w_sel_ok && r_stab == STAB_ARM)
                  r_state <= ST_CAPT;
            end
            ST_CAPT: begin
               r_state <= (w_chg || !w_sel_ok) ? ST_WAIT : ST_HOLD;
            end
            ST_HOLD: begin
               if (w_chg || !w_sel_ok)
                  r_state <= ST_WAIT;
            end
            default: r_state <= ST_WAIT;
         endcase

         if (r_state == ST_CAPT) begin
            if (w_dec_valid) begin
               r_shadow[{w_idx, 2'b00} +: 4] <= w_dec_nib;
            end else begin
               glyph_err <= 1'b1;
               r_bad     <= 1'b1;
            end
            r_seen <= w_seen_next;
            r_done <= (w_seen_next == 8'hFF);
            r_tmo  <= '0;
         end else begin
            if (r_tmo != TMO_MAX)
               r_tmo <= r_tmo + 1'b1;
            if (r_tmo == TMO_ARM) begin
               r_seen <= '0;
               r_bad  <= 1'b0;
               stale  <= 1'b1;
            end
            if (r_done) begin
               if (!r_bad) begin
                  data       <= r_shadow;
                  data_valid <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
                  stale      <= 1'b0;
               end
               r_seen <= '0;
               r_bad  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_disp_scan_decoder.sv
// tb/tb_disp_scan_decoder.sv - self-checking bench for disp_scan_decoder
`timescale 1ns/1ps
module tb_disp_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg_n;
   logic [7:0]  an_n;
   logic [31:0] data;
   logic        data_valid;
   logic        glyph_err;
   logic        stale;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   disp_scan_decoder #(.SettleCnt(4), .TimeoutCnt(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .data       (data),
      .data_valid (data_valid),
      .glyph_err  (glyph_err),
      .stale      (stale),
      .frame_cnt  (frame_cnt)
   );

   typedef struct {
      logic [31:0] data;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      logic [31:0] word;
      bit          rev;
      int          dwell;
      int          blank;
      bit          good;
   } frame_t;

   exp_t        sb_q[$];
   frame_t      vec[5];
   logic [6:0]  gtab[16];
   int          n_chk = 0;
   int          n_err = 0;
   int          ge_cnt = 0;
   int          dv_cnt = 0;
   int          ge0, dv0;
   logic [15:0] exp_cnt = 16'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (data_valid === 1'b1) begin
         dv_cnt++;
         if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_data_valid actual=%h required=none", data);
         end else begin
            e = sb_q.pop_front();
            check("frame_data", data, e.data);
            check("frame_cnt_at_valid", {16'h0, frame_cnt}, {16'h0, e.cnt});
         end
      end
      if (glyph_err === 1'b1) ge_cnt++;
   endtask

   task automatic push_exp(input logic [31:0] w);
      exp_t e;
      exp_cnt = exp_cnt + 16'd1;
      e.data = w;
      e.cnt  = exp_cnt;
      sb_q.push_back(e);
   endtask

   task automatic show_digit(input int d, input logic [6:0] seg7, input int dwell);
      an_n = ~(8'(1) << d);
      for (int c = 0; c < dwell; c++) begin
         seg_n = {1'($urandom_range(0, 1)), seg7};
         tick();
      end
   endtask

   task automatic scan(input frame_t f);
      int d;
      logic [3:0] nib;
      for (int k = 0; k < 8; k++) begin
         d   = f.rev ? 7 - k : k;
         nib = f.word[4*d +: 4];
         show_digit(d, (d == f.blank) ? 7'h7F : ~gtab[nib], f.dwell);
      end
   endtask

   task automatic idle(input int n);
      an_n  = 8'hFF;
      seg_n = 8'hFF;
      repeat (n) tick();
   endtask

   task automatic drain();
      int t = 0;
      an_n  = 8'hFF;
      seg_n = 8'hFF;
      while (sb_q.size() != 0 && t < 60) begin
         tick();
         t++;
      end
      check("drain_pending", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_data", data, 32'h0);
      check("rst_data_valid", {31'h0, data_valid}, 32'h0);
      check("rst_glyph_err", {31'h0, glyph_err}, 32'h0);
      check("rst_stale", {31'h0, stale}, 32'h1);
      check("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
   endtask

   initial begin
      gtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      vec[0] = '{word: 32'h1234ABCD, rev: 1'b0, dwell: 10, blank: -1, good: 1'b1};
      vec[1] = '{word: 32'hDEADBEEF, rev: 1'b1, dwell: 10, blank: -1, good: 1'b1};
      vec[2] = '{word: 32'hDEADBEEF, rev: 1'b1, dwell: 10, blank: -1, good: 1'b1};
      vec[3] = '{word: 32'hDEADBEEF, rev: 1'b0, dwell: 10, blank: 3,  good: 1'b0};
      vec[4] = '{word: 32'h00000000, rev: 1'b0, dwell: 10, blank: -1, good: 1'b1};

      rst   = 1'b1;
      an_n  = 8'hFF;
      seg_n = 8'hFF;
      repeat (3) tick();
      check_reset_outputs();
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         ge0 = ge_cnt;
         dv0 = dv_cnt;
         if (vec[i].good) push_exp(vec[i].word);
         scan(vec[i]);
         drain();
         idle(12);
         if (i == 0) begin
            check("first_stale", {31'h0, stale}, 32'h0);
            check("first_frame_cnt", {16'h0, frame_cnt}, 32'd1);
         end
         if (i == 2) begin
            check("rev_data", data, 32'hDEADBEEF);
            check("rev_frame_cnt", {16'h0, frame_cnt}, 32'd3);
         end
         if (i == 3) begin
            check("blank_glyph_err_pulses", 32'(ge_cnt - ge0), 32'd1);
            check("blank_no_valid", 32'(dv_cnt - dv0), 32'd0);
            check("blank_data_held", data, 32'hDEADBEEF);
         end
         if (i == 4) check("zero_frame_data", data, 32'h0);
      end

      // Ghosting: the new digit enable arrives two cycles before its segments
      push_exp(32'h1234ABCD);
      for (int d = 0; d < 8; d++) begin
         an_n = ~(8'(1) << d);
         repeat (2) tick();
         for (int c = 0; c < 10; c++) begin
            seg_n = {1'($urandom_range(0, 1)), ~gtab[4'(32'h1234ABCD >> (4*d))]};
            tick();
         end
      end
      drain();
      idle(12);
      check("ghost_data", data, 32'h1234ABCD);
      check("ghost_stale", {31'h0, stale}, 32'h0);

      // Dwell too short to settle, then timeout
      dv0 = dv_cnt;
      ge0 = ge_cnt;
      for (int r = 0; r < 3; r++)
         scan('{word: 32'hCAFEF00D, rev: 1'b0, dwell: 3, blank: -1, good: 1'b0});
      idle(80);
      check("short_no_valid", 32'(dv_cnt - dv0), 32'd0);
      check("short_no_glyph_err", 32'(ge_cnt - ge0), 32'd0);
      check("timeout_stale", {31'h0, stale}, 32'h1);
      check("timeout_data_held", data, 32'h1234ABCD);
      check("timeout_frame_cnt", {16'h0, frame_cnt}, 32'd5);

      // Reset in the middle of a frame
      for (int d = 0; d < 5; d++)
         show_digit(d, ~gtab[4'(32'h0F0F0F0F >> (4*d))], 10);
      rst = 1'b1;
      repeat (2) tick();
      check_reset_outputs();
      rst = 1'b0;
      exp_cnt = 16'd0;
      push_exp(32'h0F0F0F0F);
      scan('{word: 32'h0F0F0F0F, rev: 1'b0, dwell: 10, blank: -1, good: 1'b1});
      drain();
      idle(12);
      check("post_rst_frame_cnt", {16'h0, frame_cnt}, 32'd1);
      check("post_rst_stale", {31'h0, stale}, 32'h0);
      check("post_rst_data", data, 32'h0F0F0F0F);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
